// File: rtl/sqrt_seq_ctrl_if.sv
// Handshake bundle for the square-root sequencer: operand request, root-core
// start/done link and the held result port.
interface sqrt_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [4:0]  sel;
   logic        core_start;
   logic [31:0] core_A;
   logic        core_done;
   logic [31:0] core_ans;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] S;
   logic        out_special;
   logic        out_err;

   modport slave (
      input  in_valid, A, sel, core_done, core_ans, out_ready,
      output in_ready, core_start, core_A, out_valid, S, out_special, out_err
   );

   modport master (
      output in_valid, A, sel, core_done, core_ans, out_ready,
      input  in_ready, core_start, core_A, out_valid, S, out_special, out_err
   );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// FPAU square-root sequencer: resolves special operands locally, sends the rest
// to the shared iterative root core with a timeout, and holds each result.
module sqrt_seq_ctrl #(
   parameter int MAX_WAIT = 64
) (
   input  logic           clk,
   input  logic           rst,
   sqrt_seq_ctrl_if.slave bus
);
   localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [31:0]   s_q, s_nxt;
   logic [31:0]   a_q, a_nxt;
   logic          spec_q, spec_nxt;
   logic          err_q, err_nxt;

   // Classification runs on the incoming operand: it is only used at accept.
   logic        exp_ones, man_zero, is_inf, is_nan, is_zero;
   logic        byp;
   logic [31:0] byp_s;

   assign exp_ones = (bus.A[30:23] == 8'hFF);
   assign man_zero = (bus.A[22:0] == 23'h0);
   assign is_inf   = exp_ones & man_zero;
   assign is_nan   = exp_ones & ~man_zero;
   assign is_zero  = (bus.A[30:0] == 31'h0);

   always_comb begin
      byp   = 1'b1;
      byp_s = 32'h0;
      if (is_inf)
         byp_s = bus.sel[0] ? {bus.A[31], 31'h7F800000} : 32'h7F800000;
      else if (is_nan)
         byp_s = 32'h7FFFFFFF;
      else if (is_zero)
         byp_s = (bus.sel == 5'd0) ? 32'h7FFFFFFF : 32'h00000000;
      else if (bus.sel == 5'd0)
         byp_s = 32'h3F800000;
      else
         byp = 1'b0;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      s_nxt     = s_q;
      a_nxt     = a_q;
      spec_nxt  = spec_q;
      err_nxt   = err_q;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               a_nxt   = bus.A;
               cnt_nxt = '0;
               if (byp) begin
                  s_nxt     = byp_s;
                  spec_nxt  = 1'b1;
                  err_nxt   = 1'b0;
                  state_nxt = HOLD;
               end else begin
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_nxt = cnt + CW'(1);
            // core_done wins over a timeout landing in the same cycle
            if (bus.core_done) begin
               s_nxt     = bus.core_ans;
               spec_nxt  = 1'b0;
               err_nxt   = 1'b0;
               state_nxt = HOLD;
            end else if (cnt == LAST) begin
               s_nxt     = 32'h7FFFFFFF;
               spec_nxt  = 1'b0;
               err_nxt   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         s_q    <= 32'h0;
         a_q    <= 32'h0;
         spec_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         s_q    <= s_nxt;
         a_q    <= a_nxt;
         spec_q <= spec_nxt;
         err_q  <= err_nxt;
      end
   end

   assign bus.in_ready    = (state == IDLE) & ~rst;
   assign bus.core_start  = (state == BUSY) & (cnt == '0);
   assign bus.core_A      = a_q;
   assign bus.out_valid   = (state == HOLD);
   assign bus.S           = s_q;
   assign bus.out_special = spec_q;
   assign bus.out_err     = err_q;
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Randomized self-checking bench for sqrt_seq_ctrl against a result/latency model.
module tb_sqrt_seq_ctrl;
   localparam int MW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sqrt_seq_ctrl_if bus();

   sqrt_seq_ctrl #(.MAX_WAIT(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int ncheck = 0;
   int nerr   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncheck++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected result from the operand rules; special=1 means bypass path.
   function automatic logic [31:0] ref_s(input logic [31:0] a, input logic [4:0] sel,
                                         input logic [31:0] ans, input bit timeout,
                                         output bit special);
      bit inf, nan, zero;
      inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
      nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
      zero = (a[30:0] == 31'h0);
      special = 1'b1;
      if (inf)  return sel[0] ? ((a & 32'h80000000) | 32'h7F800000) : 32'h7F800000;
      if (nan)  return 32'h7FFFFFFF;
      if (zero) return (sel == 5'd0) ? 32'h7FFFFFFF : 32'h00000000;
      if (sel == 5'd0) return 32'h3F800000;
      special = 1'b0;
      return timeout ? 32'h7FFFFFFF : ans;
   endfunction

   // d = BUSY cycle (0 = core_start cycle) in which core_done fires; d>=MW means never.
   task automatic do_op(input logic [31:0] a, input logic [4:0] sel, input int d,
                        input logic [31:0] ans, input int hold, input bit spur);
      bit          sp_exp, dummy, timed;
      logic [31:0] s_exp, ca;
      int          k, starts, lat_exp;
      void'(ref_s(a, sel, ans, 1'b0, dummy));
      timed   = !dummy && (d >= MW);
      s_exp   = ref_s(a, sel, ans, timed, sp_exp);
      lat_exp = sp_exp ? 0 : ((d < MW) ? d + 1 : MW);

      k = 0;
      while (!bus.in_ready && k < 50) begin @(negedge clk); k++; end
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1; bus.A = a; bus.sel = sel;
      @(negedge clk);
      bus.in_valid = 1'b0;

      starts = 0; ca = 32'h0; k = 0;
      while (k < 100) begin
         bus.core_done = 1'b0;
         if (bus.out_valid) break;
         if (bus.core_start) begin starts++; ca = bus.core_A; end
         if (k == d && d < MW) begin bus.core_done = 1'b1; bus.core_ans = ans; end
         @(negedge clk);
         k++;
      end
      bus.core_done = 1'b0;
      chk("latency", 32'(k), 32'(lat_exp));
      chk("S", bus.S, s_exp);
      chk("out_special", 32'(bus.out_special), 32'(sp_exp));
      chk("out_err", 32'(bus.out_err), 32'(timed));
      chk("core_starts", 32'(starts), sp_exp ? 32'd0 : 32'd1);
      if (!sp_exp) chk("core_A", ca, a);

      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1; bus.A = ~a; bus.sel = 5'd1;
         if (spur && i == 0) begin bus.core_done = 1'b1; bus.core_ans = 32'hDEADBEEF; end
         @(negedge clk);
         bus.core_done = 1'b0;
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_S", bus.S, s_exp);
         chk("hold_flags", {30'h0, bus.out_special, bus.out_err}, {30'h0, sp_exp, timed});
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("release_valid", 32'(bus.out_valid), 32'd0);
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_S"}, bus.S, 32'h0);
      chk({tag, "_core_A"}, bus.core_A, 32'h0);
      chk({tag, "_flags"}, {29'h0, bus.core_start, bus.out_special, bus.out_err}, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      logic        s;
      int          cat;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.A = 32'h0; bus.sel = 5'd0;
      bus.core_done = 1'b0; bus.core_ans = 32'h0; bus.out_ready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      do_op(32'h40800000, 5'b00001, 3, 32'h40000000, 0, 1'b0);
      do_op(32'hFF800000, 5'b00001, 0, 32'h0, 0, 1'b0);
      do_op(32'hFF800000, 5'b00010, 0, 32'h0, 0, 1'b0);
      do_op(32'h7FC00000, 5'b10111, 0, 32'h0, 0, 1'b0);
      do_op(32'h80000000, 5'b00000, 0, 32'h0, 0, 1'b0);
      do_op(32'h80000000, 5'b00100, 0, 32'h0, 0, 1'b0);
      do_op(32'h40800000, 5'b00000, 0, 32'h0, 0, 1'b0);
      do_op(32'h3F000000, 5'b00001, 99, 32'h0, 2, 1'b1);          // timeout + late done
      do_op(32'h40400000, 5'b00011, 1, 32'h3FDDB3D7, 10, 1'b0);   // backpressure
      do_op(32'h41000000, 5'b00001, MW - 1, 32'h40350481, 0, 1'b0); // done at timeout cycle
      do_op(32'h00000001, 5'b00001, 0, 32'h1A000000, 1, 1'b1);    // denormal, done with start

      // spurious core_done in IDLE
      bus.core_done = 1'b1; bus.core_ans = 32'h12345678;
      @(negedge clk);
      bus.core_done = 1'b0;
      chk("idle_spur_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_spur_start", 32'(bus.core_start), 32'd0);
      chk("idle_spur_ready", 32'(bus.in_ready), 32'd1);

      // reset two cycles after core_start
      bus.in_valid = 1'b1; bus.A = 32'h40800000; bus.sel = 5'd1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("rst_busy_start", 32'(bus.core_start), 32'd1);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("rst_busy");
      rst = 1'b0;
      bus.core_done = 1'b1; bus.core_ans = 32'h40000000;
      @(negedge clk);
      bus.core_done = 1'b0;
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_S", bus.S, 32'h0);
      do_op(32'h40800000, 5'b00001, 2, 32'h40000000, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         cat = int'($urandom_range(0, 4));
         s   = 1'($urandom_range(0, 1));
         case (cat)
            0: a = {s, 8'hFF, 23'h0};
            1: a = {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            2: a = {s, 31'h0};
            3: a = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
            default: a = {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
         endcase
         do_op(a, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               int'($urandom_range(0, MW + 1)), $urandom,
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", ncheck, nerr);
      $finish;
   end
endmodule
